// File: rtl/mem_bus_unit.sv
// mem_bus_unit: MAR/MDR pair plus internal word-addressed RAM.
// A multi-cycle access is sequenced by a wait-state FSM with a busy/done/err handshake.
// Optional feature: define MEM_BUS_BYTE_EN to add per-byte write strobes (byte_en).
module mem_bus_unit #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              read,
    input  logic              write,
`ifdef MEM_BUS_BYTE_EN
    input  logic [DATA_W/8-1:0] byte_en,
`endif
    output logic [DATA_W-1:0] mar_out,
    output logic [DATA_W-1:0] mdr_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   mar_q, mar_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic                op_wr_q, op_wr_d;
    logic [IDX_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                mem_we;
    logic                addr_oob;
`ifdef MEM_BUS_BYTE_EN
    logic [BE_W-1:0]     be_q, be_d;
`endif

    logic [DATA_W-1:0]   mem_q [DEPTH];

    // Address range check on the live MAR field, evaluated when a request is sampled
    assign addr_oob = {1'b0, mar_q[ADDR_W-1:0]} >= DEPTH_LIM;

    // Next-state, register loads and access sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        mem_we  = 1'b0;
`ifdef MEM_BUS_BYTE_EN
        be_d    = be_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mar_in) mar_d = bus_in;
                if (mdr_in) mdr_d = bus_in;
                if (read || write) begin
                    if ((read && write) || addr_oob) begin
                        err_d = 1'b1;
                    end else begin
                        // Request uses pre-edge MAR/MDR, so snapshot them here
                        op_wr_d = write;
                        addr_d  = mar_q[IDX_W-1:0];
                        wdata_d = mdr_q;
`ifdef MEM_BUS_BYTE_EN
                        be_d    = byte_en;
`endif
                        if (WAIT_CYCLES == 0) begin
                            state_d = ST_ACCESS;
                        end else begin
                            state_d = ST_WAIT;
                            cnt_d   = CNT_W'(WAIT_CYCLES);
                        end
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_ACCESS;
                    cnt_d   = '0;
                end
            end
            ST_ACCESS: begin
                if (op_wr_q) mem_we = 1'b1;
                else         mdr_d  = mem_q[addr_q];
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and register file, asynchronously cleared
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mar_q   <= '0;
            mdr_q   <= '0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MEM_BUS_BYTE_EN
            be_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef MEM_BUS_BYTE_EN
            be_q    <= be_d;
`endif
        end
    end

    // RAM write port; contents deliberately not reset
    always_ff @(posedge clock) begin
        if (mem_we) begin
`ifdef MEM_BUS_BYTE_EN
            for (int k = 0; k < int'(BE_W); k++) begin
                if (be_q[k]) mem_q[addr_q][8*k +: 8] <= wdata_q[8*k +: 8];
            end
`else
            mem_q[addr_q] <= wdata_q;
`endif
        end
    end

    assign mar_out = mar_q;
    assign mdr_out = mdr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Scoreboard bench for mem_bus_unit: a WAIT_CYCLES=2/DEPTH=256 unit and a WAIT_CYCLES=0 unit.
module tb_mem_bus_unit;

    logic        clock;
    logic        clear;
    logic [31:0] bus_in;
    logic        mar_in, mdr_in;
    logic        rd, wr, rd0, wr0;
    logic [31:0] mar_o, mdr_o, mar0, mdr0;
    logic        busy_o, done_o, err_o, busy0, done0, err0;
`ifdef MEM_BUS_BYTE_EN
    logic [3:0]  be;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    typedef struct {
        bit          is_err;
        logic [31:0] mdr;
        int          cyc;
    } exp_t;

    exp_t q_main[$];
    exp_t q_w0[$];

    mem_bus_unit #(.DATA_W(32), .ADDR_W(9), .DEPTH(256), .WAIT_CYCLES(2)) u_main (
        .clock(clock), .clear(clear), .bus_in(bus_in),
        .mar_in(mar_in), .mdr_in(mdr_in), .read(rd), .write(wr),
`ifdef MEM_BUS_BYTE_EN
        .byte_en(be),
`endif
        .mar_out(mar_o), .mdr_out(mdr_o), .busy(busy_o), .done(done_o), .err(err_o)
    );

    mem_bus_unit #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_CYCLES(0)) u_w0 (
        .clock(clock), .clear(clear), .bus_in(bus_in),
        .mar_in(mar_in), .mdr_in(mdr_in), .read(rd0), .write(wr0),
`ifdef MEM_BUS_BYTE_EN
        .byte_en(be),
`endif
        .mar_out(mar0), .mdr_out(mdr0), .busy(busy0), .done(done0), .err(err0)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Pop the next expected event for one DUT and compare kind, timing and MDR
    task automatic mon_pop(input int sel, input logic d, input logic e, input logic [31:0] m);
        exp_t x;
        if ((sel == 0 && q_main.size() == 0) || (sel == 1 && q_w0.size() == 0)) begin
            chk(sel == 0 ? "unexpected_event_main" : "unexpected_event_w0", 32'(1), 32'(0));
            return;
        end
        if (sel == 0) x = q_main.pop_front();
        else          x = q_w0.pop_front();
        chk("evt_kind", {30'd0, e, d}, x.is_err ? 32'd2 : 32'd1);
        chk("evt_cycle", 32'(cyc), 32'(x.cyc));
        chk("evt_mdr", m, x.mdr);
    endtask

    // Monitor: any done/err pulse is checked against the scoreboard
    always @(negedge clock) begin
        if (!clear) begin
            if (done_o || err_o) mon_pop(0, done_o, err_o, mdr_o);
            if (done0 || err0)   mon_pop(1, done0, err0, mdr0);
        end
    end

    task automatic load(input bit m, input bit d, input logic [31:0] v);
        @(negedge clock);
        bus_in = v;
        mar_in = m;
        mdr_in = d;
        @(negedge clock);
        mar_in = 1'b0;
        mdr_in = 1'b0;
        if (m) chk("mar_load", mar_o, v);
        if (d) chk("mdr_load", mdr_o, v);
    endtask

    // Issue one request, push its expected event, and track busy cycle by cycle
    task automatic do_req(input int sel, input bit r, input bit w, input bit is_err,
                          input logic [31:0] exp_mdr, input bit poke,
                          input bit ld, input logic [31:0] ld_v);
        exp_t x;
        int   wc;
        int   n;
        logic b;
        wc = (sel == 0) ? 2 : 0;
        @(negedge clock);
        if (sel == 0) begin rd = r; wr = w; end
        else          begin rd0 = r; wr0 = w; end
        if (ld) begin bus_in = ld_v; mar_in = 1'b1; end
        x.is_err = is_err;
        x.mdr    = exp_mdr;
        x.cyc    = is_err ? cyc + 1 : cyc + wc + 2;
        if (sel == 0) q_main.push_back(x);
        else          q_w0.push_back(x);
        n = is_err ? 2 : wc + 3;
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            if (k == 1) begin
                rd = 1'b0; wr = 1'b0; rd0 = 1'b0; wr0 = 1'b0; mar_in = 1'b0;
                if (poke) begin bus_in = 32'd7; mar_in = 1'b1; end
            end
            if (k == 2) mar_in = 1'b0;
            b = (sel == 0) ? busy_o : busy0;
            chk("busy", 32'(b), 32'(!is_err && k <= wc + 2));
        end
        chk("queue_drained", 32'((sel == 0) ? q_main.size() : q_w0.size()), 32'(0));
    endtask

    initial begin
        clear  = 1'b1;
        bus_in = '0;
        mar_in = 1'b0; mdr_in = 1'b0;
        rd = 1'b0; wr = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
`ifdef MEM_BUS_BYTE_EN
        be = 4'hF;
`endif
        repeat (2) @(negedge clock);
        chk("rst_mar", mar_o, 32'd0);
        chk("rst_mdr", mdr_o, 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        clear = 1'b0;

        // Write then read back address 5
        load(1, 0, 32'd5);
        load(0, 1, 32'hDEADBEEF);
        do_req(0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0);
        load(0, 1, 32'h0);
        do_req(0, 1, 0, 0, 32'hDEADBEEF, 0, 0, 0);

        // read+write together: error, MDR unchanged
        do_req(0, 1, 1, 1, 32'hDEADBEEF, 0, 0, 0);

        // MAR load during WAIT is ignored; access uses old address
        load(1, 1, 32'h07070707);
        load(1, 0, 32'd7);
        do_req(0, 0, 1, 0, 32'h07070707, 0, 0, 0);
        load(1, 1, 32'd5);
        load(0, 1, 32'h0);
        do_req(0, 1, 0, 0, 32'hDEADBEEF, 1, 0, 0);
        chk("mar_frozen", mar_o, 32'd5);

        // Last valid address, then out-of-range read and write
        load(1, 0, 32'd255);
        load(0, 1, 32'h55AA55AA);
        do_req(0, 0, 1, 0, 32'h55AA55AA, 0, 0, 0);
        load(0, 1, 32'h0);
        do_req(0, 1, 0, 0, 32'h55AA55AA, 0, 0, 0);
        load(1, 0, 32'd256);
        do_req(0, 1, 0, 1, 32'h55AA55AA, 0, 0, 0);
        do_req(0, 0, 1, 1, 32'h55AA55AA, 0, 0, 0);

        // Bits above ADDR_W do not take part in addressing
        load(1, 0, 32'h0000_0205);
        do_req(0, 1, 0, 0, 32'hDEADBEEF, 0, 0, 0);

        // MAR load coincident with request: request uses pre-edge MAR, load still lands
        load(0, 1, 32'h0);
        do_req(0, 1, 0, 0, 32'hDEADBEEF, 0, 1, 32'd255);
        chk("mar_same_edge", mar_o, 32'd255);

        // clear during WAIT of a write aborts it
        load(1, 1, 32'd9);
        load(0, 1, 32'hCAFEF00D);
        do_req(0, 0, 1, 0, 32'hCAFEF00D, 0, 0, 0);
        load(0, 1, 32'h12345678);
        @(negedge clock);
        wr = 1'b1;
        @(negedge clock);
        wr = 1'b0;
        chk("pre_clear_busy", 32'(busy_o), 32'd1);
        clear = 1'b1;
        #1;
        chk("clr_busy", 32'(busy_o), 32'd0);
        chk("clr_mar", mar_o, 32'd0);
        chk("clr_mdr", mdr_o, 32'd0);
        @(negedge clock);
        clear = 1'b0;
        repeat (6) @(negedge clock);
        chk("clr_no_done", 32'(q_main.size()), 32'd0);
        load(1, 0, 32'd9);
        do_req(0, 1, 0, 0, 32'hCAFEF00D, 0, 0, 0);

        // Zero-wait-state unit
        load(1, 1, 32'd3);
        load(0, 1, 32'h0BADF00D);
        do_req(1, 0, 1, 0, 32'h0BADF00D, 0, 0, 0);
        load(0, 1, 32'h0);
        do_req(1, 1, 0, 0, 32'h0BADF00D, 0, 0, 0);

`ifdef MEM_BUS_BYTE_EN
        // Byte-lane writes
        load(1, 1, 32'd10);
        load(0, 1, 32'hAABBCCDD);
        be = 4'hF;
        do_req(0, 0, 1, 0, 32'hAABBCCDD, 0, 0, 0);
        load(0, 1, 32'h11223344);
        be = 4'b0101;
        do_req(0, 0, 1, 0, 32'h11223344, 0, 0, 0);
        load(0, 1, 32'hFFFFFFFF);
        be = 4'b0000;
        do_req(0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0);
        load(0, 1, 32'h0);
        be = 4'hF;
        do_req(0, 1, 0, 0, 32'hAA22CC44, 0, 0, 0);
`endif

        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
